led_arbiter: RTL and testbench
==============================

# led_arbiter

Round-robin arbiter that shares the board's 8 user LEDs between up to 8 on-chip requesters (status monitors, debug counters, error flags). It sits between the requester logic and the `leds` output pins in `top`, runs on the internal OSCH clock and enforces a minimum display time so each owner's pattern is visible to a human. When no requester is active it drives an idle pattern.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `HOLD_CYCLES`, 1330000: minimum ownership/display time in clocks (10 ms at 133 MHz), ≥1.
- `IDLE_PATTERN`, 8'b10101010: LED value when unowned.

- `clock`  in  1: system clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  NREQ: request per requester, level-sensitive.
- `data`  in  8*NREQ: LED value per requester; requester i uses `data[8*i+7:8*i]`.
- `grant`  out  NREQ: registered, one-hot or zero; current owner.
- `leds`  out  8: registered LED drive.

## Operation
- FSM states: IDLE, OWN, LINGER. Registers: state, owner index, `last` (round-robin pointer), hold counter, `grant`, `leds`.
- Arbitration (used wherever "arbitrate" appears): search from `last+1` upward, wrapping mod NREQ; first set `req` bit wins. The winner becomes owner, `last` := winner, `grant` := one-hot(winner), hold := HOLD_CYCLES-1, state := OWN. With no request: `grant` := 0, state := IDLE.
- IDLE: `leds` := idle value (see Configuration). Arbitrate every cycle.
- OWN: `leds` := data[owner] every cycle. Hold decrements while nonzero (saturates at 0).
  - `req[owner]` low, hold = 0: arbitrate.
  - `req[owner]` low, hold > 0: `grant` := 0, `leds` frozen, state := LINGER.
  - `req[owner]` high, hold = 0, any other `req` high: arbitrate. The current owner is lowest priority, so the other requester wins.
  - Otherwise stay.
- LINGER: `leds` unchanged; hold decrements. When hold = 0, arbitrate; the requester that just left may win again if it is the only one requesting.
- Reset values: state IDLE, `grant` 0, `leds` IDLE_PATTERN, `last` NREQ-1 (requester 0 first), hold 0, idle counter 0.
- Reset takes precedence in any state. An owner mid-hold is dropped immediately.

## Timing
- `req` sampled high at edge N in IDLE: `grant` valid after edge N. `leds` = data[owner] sampled at edge N+1, visible after edge N+1.
- Ownership lasts at least HOLD_CYCLES clocks from the `grant` rise, whether the owner stays (OWN) or drops out (LINGER).
- Owner handover with a waiting requester: old `grant` falls and new `grant` rises on the same edge; never two bits set.
- `data` is sampled every OWN cycle, so live values pass through with one register of latency.
- HOLD_CYCLES = 1: hold is loaded with 0, LINGER is never entered, and the grant can rotate every cycle.
- Hold counter width is $clog2(HOLD_CYCLES+1).

## Configuration
- `LED_ARB_IDLE_COUNT_EN` defined: adds a 32-bit free-running counter. It is cleared by `reset` and increments every clock in all states. In IDLE, `leds` := ~counter[31:24].
- Not defined: no counter is built. In IDLE, `leds` := IDLE_PATTERN.

## Test plan
All scenarios use NREQ=4, HOLD_CYCLES=4, data[i] = 8'h10+i.
- Reset, no `req` for 10 cycles -> `grant`=0, `leds`=8'hAA, or the ~counter[31:24] value when `LED_ARB_IDLE_COUNT_EN` is defined.
- `req`=4'b0100 held -> `grant`=4'b0100 one cycle after sampling, `leds`=8'h12 on the next edge; no change while held alone.
- `req`=4'b1111 held 40 cycles -> grant rotates 0→1→2→3→0, each owner for exactly 4 cycles; `leds` follow 10,11,12,13 with one-cycle lag.
- Owner 1 drops `req` one cycle after grant while `req[3]` is high -> `grant`=0 and `leds` frozen at 8'h11 for the rest of the 4-cycle hold, then `grant`=4'b1000.
- Assert `reset` during OWN with hold at 2 -> next cycle `grant`=0, `leds`=8'hAA, and the next arbitration starts from requester 0.

Source files
------------

// File: rtl/led_arbiter.sv
// led_arbiter
//   Round-robin owner of the board's 8 user LEDs. Each requester that wins
//   keeps the LEDs for at least HOLD_CYCLES clocks so its pattern is
//   readable by a person. The hold still runs after an owner drops its
//   request (LINGER). When nobody owns the LEDs, an idle value is shown.
//
// Optional feature macro: LED_ARB_IDLE_COUNT_EN
//   When defined, a 32-bit free-running counter is built, and in IDLE the
//   LEDs show ~counter[31:24]. When not defined, IDLE shows IDLE_PATTERN.
//
// Parameters
//   NREQ         number of requesters (2..8)
//   HOLD_CYCLES  minimum ownership time in clocks (>=1)
//   IDLE_PATTERN LED value when unowned
// Ports
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset
//   req    in   [NREQ]   level request per requester
//   data   in   [8*NREQ] LED value per requester, requester i at [8i+7:8i]
//   grant  out  [NREQ]   registered owner, one-hot or zero
//   leds   out  [8]      registered LED drive
module led_arbiter #(
    parameter int          NREQ         = 4,
    parameter int          HOLD_CYCLES  = 1330000,
    parameter logic [7:0]  IDLE_PATTERN = 8'b10101010
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   data,
    output logic [NREQ-1:0]     grant,
    output logic [7:0]          leds
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, OWN, LINGER} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [7:0]      leds_q, leds_d;

    logic [7:0]      idle_val;
`ifdef LED_ARB_IDLE_COUNT_EN
    logic [31:0]     cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q + 32'd1;
        idle_val = ~cnt_q[31:24];
    end
`else
    always_comb begin
        idle_val = IDLE_PATTERN;
    end
`endif

    // Round-robin search starting just after the previous winner, so the
    // previous winner is always the last candidate considered.
    logic          arb_found;
    logic [IW-1:0] arb_idx;

    always_comb begin
        int idx;
        idx       = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!arb_found && req[idx]) begin
                arb_found = 1'b1;
                arb_idx   = IW'(idx);
            end
        end
    end

    logic [7:0]    owner_data;
    logic [HW-1:0] hold_dec;
    logic          others_req;
    logic          arb;

    assign owner_data = data[8*int'(owner_q) +: 8];
    assign hold_dec   = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
    // grant_q is the owner's one-hot in OWN, so this masks the owner out.
    assign others_req = (req & ~grant_q) != '0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        leds_d  = leds_q;
        arb     = 1'b0;

        case (state_q)
            IDLE: begin
                leds_d = idle_val;
                arb    = 1'b1;
            end
            OWN: begin
                leds_d = owner_data;
                hold_d = hold_dec;
                if (!req[owner_q]) begin
                    if (hold_q == '0) begin
                        arb = 1'b1;
                    end else begin
                        // Owner left early: release the grant but keep its
                        // last pattern on the LEDs until the hold expires.
                        grant_d = '0;
                        state_d = LINGER;
                    end
                end else if (hold_q == '0 && others_req) begin
                    arb = 1'b1;
                end
            end
            LINGER: begin
                hold_d = hold_dec;
                if (hold_q == '0) arb = 1'b1;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (arb) begin
            if (arb_found) begin
                owner_d          = arb_idx;
                last_d           = arb_idx;
                grant_d          = '0;
                grant_d[arb_idx] = 1'b1;
                hold_d           = HW'(HOLD_CYCLES - 1);
                state_d          = OWN;
            end else begin
                grant_d = '0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            hold_q  <= '0;
            grant_q <= '0;
            leds_q  <= IDLE_PATTERN;
`ifdef LED_ARB_IDLE_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            leds_q  <= leds_d;
`ifdef LED_ARB_IDLE_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign grant = grant_q;
    assign leds  = leds_q;

endmodule

// File: tb/tb_led_arbiter.sv
module tb_led_arbiter;
    localparam int NREQ = 4;
    localparam int HOLD = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   grant;
    logic [7:0]        leds;

    always #5 clock = ~clock;

    led_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .IDLE_PATTERN(8'hAA)) dut (
        .clock(clock), .reset(reset), .req(req), .data(data),
        .grant(grant), .leds(leds)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the LEDs, how many edges since the grant
    // rose, and whether the owner has already left (display still held).
    int              m_own;
    int              m_last;
    int              m_elapsed;
    bit              m_left;
    logic [31:0]     m_cnt;
    logic [NREQ-1:0] exp_grant;
    logic [7:0]      exp_leds;

    function automatic logic [7:0] idle_val();
`ifdef LED_ARB_IDLE_COUNT_EN
        return ~m_cnt[31:24];
`else
        return 8'hAA;
`endif
    endfunction

    task automatic model_reset();
        m_own = -1; m_last = NREQ - 1; m_elapsed = 0; m_left = 0;
        m_cnt = 0; exp_grant = '0; exp_leds = 8'hAA;
    endtask

    task automatic pick_next();
        int w;
        int i;
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
            i = (m_last + k) % NREQ;
            if (w < 0 && req[i]) w = i;
        end
        if (w >= 0) begin
            m_own = w; m_last = w; m_elapsed = 0; m_left = 0;
            exp_grant = '0; exp_grant[w] = 1'b1;
        end else begin
            m_own = -1; m_left = 0; exp_grant = '0;
        end
    endtask

    task automatic model_step();
        bit expired;
        bit others;
        m_elapsed++;
        expired = (m_elapsed >= HOLD);
        if (m_own < 0) begin
            exp_leds = idle_val();
            pick_next();
        end else if (m_left) begin
            if (expired) pick_next();
        end else begin
            exp_leds = data[8*m_own +: 8];
            others = 0;
            for (int i = 0; i < NREQ; i++) if (i != m_own && req[i]) others = 1;
            if (!req[m_own]) begin
                if (expired) pick_next();
                else begin m_left = 1; exp_grant = '0; end
            end else if (expired && others) begin
                pick_next();
            end
        end
        m_cnt = m_cnt + 1;
    endtask

    // One clock: model follows the DUT's edge, then outputs settle for the
    // negedge-side comparison.
    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else model_step();
        @(negedge clock);
    endtask

    task automatic default_data();
        for (int i = 0; i < NREQ; i++) data[8*i +: 8] = 8'h10 + 8'(i);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0;
        tick(); tick();
        checks++;
        if (grant !== '0 || leds !== 8'hAA) begin
            errors++;
            $display("FAIL reset_values: grant=%b leds=%h want grant=0 leds=aa", grant, leds);
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (grant !== '0 || leds !== idle_val_prev(c)) begin
                errors++;
                $display("FAIL idle_cycle%0d: grant=%b leds=%h want grant=0 leds=%h",
                         c, grant, leds, idle_val_prev(c));
            end
        end
    endtask

    // Idle LED value after cycle c following reset release (counter was c).
    function automatic logic [7:0] idle_val_prev(int c);
`ifdef LED_ARB_IDLE_COUNT_EN
        logic [31:0] v;
        v = 32'(c);
        return ~v[31:24];
`else
        return 8'hAA + 8'(c - c);
`endif
    endfunction

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if (grant !== 4'b0100) begin
                errors++;
                $display("FAIL single_grant c%0d: got %b want 0100", c, grant);
            end
            if (c >= 2) begin
                checks++;
                if (leds !== 8'h12) begin
                    errors++;
                    $display("FAIL single_leds c%0d: got %h want 12", c, leds);
                end
            end
        end
    endtask

    task automatic test_rotate();
        logic [NREQ-1:0] g;
        logic [7:0]      l;
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 40; c++) begin
            tick();
            g = '0; g[((c - 1) / HOLD) % NREQ] = 1'b1;
            checks++;
            if (grant !== g || grant !== exp_grant) begin
                errors++;
                $display("FAIL rotate_grant c%0d: got %b want %b", c, grant, g);
            end
            if (c >= 2) begin
                l = 8'h10 + 8'(((c - 2) / HOLD) % NREQ);
                checks++;
                if (leds !== l || leds !== exp_leds) begin
                    errors++;
                    $display("FAIL rotate_leds c%0d: got %h want %h", c, leds, l);
                end
            end
        end
    endtask

    task automatic test_linger();
        do_reset();
        req = 4'b1010;
        tick();
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL linger_first_grant: got %b want 0010", grant);
        end
        req = 4'b1000;
        for (int c = 2; c <= 4; c++) begin
            tick();
            checks++;
            if (grant !== '0 || leds !== 8'h11) begin
                errors++;
                $display("FAIL linger_hold c%0d: grant=%b leds=%h want 0000/11", c, grant, leds);
            end
        end
        tick();
        checks++;
        if (grant !== 4'b1000 || leds !== 8'h11) begin
            errors++;
            $display("FAIL linger_handover: grant=%b leds=%h want 1000/11", grant, leds);
        end
        tick();
        checks++;
        if (leds !== 8'h13) begin
            errors++;
            $display("FAIL linger_new_leds: got %h want 13", leds);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req = 4'b0110;
        tick(); tick();   // owner 1, hold now 2
        reset = 1'b1;
        tick();
        checks++;
        if (grant !== '0 || leds !== 8'hAA) begin
            errors++;
            $display("FAIL midhold_reset: grant=%b leds=%h want 0000/aa", grant, leds);
        end
        reset = 1'b0;
        req = 4'b0101;    // stale pointer would pick 2; fresh pointer picks 0
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL midhold_restart: got %b want 0001", grant);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) < 2);
            req   = NREQ'($urandom);
            if ($urandom_range(0, 3) == 0) req = '0;
            for (int i = 0; i < NREQ; i++) data[8*i +: 8] = 8'($urandom);
            tick();
            checks++;
            if (grant !== exp_grant || leds !== exp_leds) begin
                errors++;
                $display("FAIL random c%0d: grant=%b leds=%h want %b/%h",
                         c, grant, leds, exp_grant, exp_leds);
            end
        end
        reset = 1'b0;
        default_data();
    endtask

    initial begin
        reset = 1'b1; req = '0; data = '0;
        default_data();
        model_reset();
        test_reset();
        test_single();
        test_rotate();
        test_linger();
        test_reset_mid_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
